// File: rtl/rca_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM states,
// slice width and counter sizing.
package rca_seq_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Start/done handshake and operand/result bus of the sequencer.
// Optional SUB_EN adds the 'sub' request bit.
interface rca_seq_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = rca_seq_ctrl_pkg::NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
`ifdef SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    modport master (
`ifdef SUB_EN
        output sub,
`endif
        output start, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
`ifdef SUB_EN
        input  sub,
`endif
        input  start, a, b, ci,
        output busy, done, s, co, ovf
    );

endinterface

// File: rtl/rca_seq_ctrl_rca.sv
// Existing 4-bit ripple-carry adder reused by the sequencer datapath.
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial adder: one 4-bit rca processes a NIBBLES*4-bit add, LSB nibble first.
// Define SUB_EN to add the 'sub' request (A - B).
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    rca_seq_ctrl_if.slave  bus
);

    localparam int unsigned W  = NIBBLE_W * NIBBLES;
    localparam int unsigned CW = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  s_q, s_d;
    logic          co_q, co_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;

    logic [W-1:0]          b_eff;
    logic                  ci_eff;
    logic [NIBBLE_W-1:0]   sum_nib;
    logic                  rca_co;

    always_comb begin
`ifdef SUB_EN
        b_eff  = bus.sub ? ~bus.b : bus.b;
        ci_eff = bus.sub ? 1'b1 : bus.ci;
`else
        b_eff  = bus.b;
        ci_eff = bus.ci;
`endif
    end

    rca U0_rca (
        .a  (a_sh_q[NIBBLE_W-1:0]),
        .b  (b_sh_q[NIBBLE_W-1:0]),
        .ci (carry_q),
        .s  (sum_nib),
        .co (rca_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = b_eff;
                    carry_d = ci_eff;
                    a_msb_d = bus.a[W-1];
                    b_msb_d = b_eff[W-1];
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // Sum nibbles enter from the top so the LSB nibble lands at the bottom after NIBBLES steps.
                res_d   = {sum_nib, res_q[W-1:NIBBLE_W]};
                a_sh_d  = a_sh_q >> NIBBLE_W;
                b_sh_d  = b_sh_q >> NIBBLE_W;
                carry_d = rca_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = res_d;
                    co_d    = rca_co;
                    ovf_d   = (a_msb_q == b_msb_q) && (sum_nib[NIBBLE_W-1] != a_msb_q);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign bus.busy = (state_q == ADD);
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with NIBBLES=4; SUB_EN vectors run when the macro is defined.
module tb_rca_seq_ctrl;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat;
    int   done_seen;

    rca_seq_ctrl_if #(.NIBBLES(4)) bus ();

    rca_seq_ctrl #(.NIBBLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents operands with start for one cycle; returns at the negedge after the accepting edge.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.ci    = ci;
`ifdef SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("sub request ignored in add-only build");
`endif
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ci    = 1'b0;
`ifdef SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_s",    32'(bus.s),    32'h0);
        check("reset_co",   32'(bus.co),   32'h0);
        check("reset_ovf",  32'(bus.ovf),  32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // basic add
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        check("t1_busy", 32'(bus.busy), 32'h1);
        wait_done(lat);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_s",    32'(bus.s),    32'h5555);
        check("t1_co",   32'(bus.co),   32'h0);
        check("t1_ovf",  32'(bus.ovf),  32'h0);
        check("t1_busy_done", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus.done), 32'h0);
        check("t1_s_hold", 32'(bus.s), 32'h5555);

        // full ripple through every nibble
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_s",   32'(bus.s),   32'h0000);
        check("t2_co",  32'(bus.co),  32'h1);
        check("t2_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);

        launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_done(lat);
        check("t3a_s",   32'(bus.s),   32'hFFFF);
        check("t3a_co",  32'(bus.co),  32'h1);
        check("t3a_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);

        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat);
        check("t3b_s",   32'(bus.s),   32'h8000);
        check("t3b_co",  32'(bus.co),  32'h0);
        check("t3b_ovf", 32'(bus.ovf), 32'h1);
        @(negedge clk);

        // start while busy is ignored; operand changes while busy have no effect
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.ci    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("t4_latency", 32'(lat), 32'd3);
        check("t4_s",  32'(bus.s),  32'h3333);
        check("t4_co", 32'(bus.co), 32'h0);
        // back-to-back: start during the done cycle
        launch(16'h0100, 16'h0200, 1'b0, 1'b0);
        check("t4_b2b_busy", 32'(bus.busy), 32'h1);
        check("t4_s_hold_busy", 32'(bus.s), 32'h3333);
        wait_done(lat);
        check("t4_b2b_latency", 32'(lat), 32'd4);
        check("t4_b2b_s", 32'(bus.s), 32'h0300);
        @(negedge clk);

        // async reset mid-operation
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_busy", 32'(bus.busy), 32'h0);
        check("t5_done", 32'(bus.done), 32'h0);
        check("t5_s",    32'(bus.s),    32'h0);
        check("t5_co",   32'(bus.co),   32'h0);
        check("t5_ovf",  32'(bus.ovf),  32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("t5_no_done", 32'(done_seen), 32'd0);
        check("t5_idle_busy", 32'(bus.busy), 32'h0);

`ifdef SUB_EN
        launch(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(lat);
        check("t6a_latency", 32'(lat), 32'd4);
        check("t6a_s",   32'(bus.s),   32'hFFFE);
        check("t6a_co",  32'(bus.co),  32'h0);
        check("t6a_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);
        launch(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done(lat);
        check("t6b_s",   32'(bus.s),   32'h7FFF);
        check("t6b_co",  32'(bus.co),  32'h1);
        check("t6b_ovf", 32'(bus.ovf), 32'h1);
        @(negedge clk);
        bus.sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
